// File: rtl/id_pkg.sv
// ----------------------------------------------------------------------------
// id_pkg
//   Shared constants and helpers for the decode/forwarding stage.
//   XLEN / NREG    : default datapath width and architectural register count
//   AW             : register address width
//   FS2DS_W        : width of the {inst, pc} payload from IF
//   MAX_FWD        : largest bypass-source count supported by fwd_sel
//   fwd_sel()      : one-hot producer vector -> binary producer index
// ----------------------------------------------------------------------------
package id_pkg;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int AW      = $clog2(NREG);
    localparam int FS2DS_W = 2 * XLEN;

    localparam int MAX_FWD = 16;
    localparam int FWD_IW  = $clog2(MAX_FWD);

    // OR-reduction encoder: exact for one-hot inputs, which is all the
    // bypass network ever feeds it. An all-zero vector encodes to 0.
    function automatic logic [FWD_IW-1:0] fwd_sel(input logic [MAX_FWD-1:0] onehot);
        logic [FWD_IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_FWD; i++) begin
            if (onehot[i]) begin
                idx = idx | FWD_IW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/id_fwd_stage_regfile.sv
// ----------------------------------------------------------------------------
// regfile_p
//   Architectural register file: two combinational read ports, one write port
//   committed at the rising clock edge. Register 0 always reads as zero and is
//   never written. Contents are deliberately not reset.
//   clk            : clock
//   we/waddr/wdata : write port
//   raddr1/rdata1  : read port 1
//   raddr2/rdata2  : read port 2
// ----------------------------------------------------------------------------
module regfile_p #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/id_fwd_stage.sv
// ----------------------------------------------------------------------------
// id_fwd_stage
//   Decode-stage pipeline register between IF and EX. Holds the {inst, pc}
//   payload and resolves both source operands from the register file, the WB
//   write port and NFWD in-flight producers (index 0 = youngest). Stalls when
//   the youngest matching producer has no result yet. Supports flush,
//   branch-kill of the wrong-path fetch, and a saturating stall counter.
//   Ports:
//     clk, resetn            : clock, synchronous active-low reset
//     fs2ds_valid/bus        : IF payload {inst, pc}; ds_allowin back to IF
//     es_allowin/ds2es_valid : handshake to EX
//     ds_inst, ds_pc         : latched payload
//     dec_raddr1/2, need1/2  : source addresses and use flags from the decoder
//     br_taken, flush        : redirect from ID, flush from later stages
//     fwd_we/waddr/wdata/rdy : NFWD producer bypass buses (slice i = producer i)
//     wb_we/waddr/wdata      : register file write port
//     rj_value, rkd_value    : resolved operands
//     stall_cnt              : saturating interlock-cycle count
// ----------------------------------------------------------------------------
module id_fwd_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NFWD  = 3,
    parameter int CNT_W = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fs2ds_valid,
    output logic                 ds_allowin,
    input  logic [2*XLEN-1:0]    fs2ds_bus,
    input  logic                 es_allowin,
    output logic                 ds2es_valid,
    output logic [XLEN-1:0]      ds_inst,
    output logic [XLEN-1:0]      ds_pc,
    input  logic [AW-1:0]        dec_raddr1,
    input  logic [AW-1:0]        dec_raddr2,
    input  logic                 dec_need1,
    input  logic                 dec_need2,
    input  logic                 br_taken,
    input  logic                 flush,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_waddr,
    input  logic [NFWD*XLEN-1:0] fwd_wdata,
    input  logic [NFWD-1:0]      fwd_rdy,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_waddr,
    input  logic [XLEN-1:0]      wb_wdata,
    output logic [XLEN-1:0]      rj_value,
    output logic [XLEN-1:0]      rkd_value,
    output logic [CNT_W-1:0]     stall_cnt
);

    import id_pkg::*;

    logic             ds_valid_q, ds_valid_d;
    logic [XLEN-1:0]  ds_inst_q, ds_inst_d;
    logic [XLEN-1:0]  ds_pc_q, ds_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [XLEN-1:0]  rf_rdata1, rf_rdata2;
    logic             ready_go;
    logic             ds_fire;
    logic             br_kill;

    regfile_p #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .we     (wb_we),
        .waddr  (wb_waddr),
        .wdata  (wb_wdata),
        .raddr1 (dec_raddr1),
        .rdata1 (rf_rdata1),
        .raddr2 (dec_raddr2),
        .rdata2 (rf_rdata2)
    );

    // Producer buses padded out to MAX_FWD entries so the encoded winner index
    // can address them directly; padding entries are never selected.
    logic [XLEN-1:0]    fwd_data [MAX_FWD];
    logic [MAX_FWD-1:0] rdy_pad;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_FWD; gi++) begin : g_pad
            if (gi < NFWD) begin : g_real
                assign fwd_data[gi] = fwd_wdata[gi*XLEN +: XLEN];
                assign rdy_pad[gi]  = fwd_rdy[gi];
            end else begin : g_zero
                assign fwd_data[gi] = '0;
                assign rdy_pad[gi]  = 1'b0;
            end
        end
    endgenerate

    // One bypass network per source operand (0 = rj, 1 = rk/rd).
    genvar gs;
    generate
        for (gs = 0; gs < 2; gs++) begin : g_src
            logic [AW-1:0]      addr;
            logic               need;
            logic [XLEN-1:0]    rf_val;
            logic [NFWD-1:0]    match;
            logic [NFWD-1:0]    win;
            logic [MAX_FWD-1:0] win_pad;
            logic [FWD_IW-1:0]  sel;
            logic               any_fwd;
            logic               wb_match;
            logic [XLEN-1:0]    val;
            logic               stall;

            assign addr   = (gs == 0) ? dec_raddr1 : dec_raddr2;
            assign need   = (gs == 0) ? dec_need1  : dec_need2;
            assign rf_val = (gs == 0) ? rf_rdata1  : rf_rdata2;

            for (gi = 0; gi < NFWD; gi++) begin : g_match
                assign match[gi] = fwd_we[gi]
                                 & (fwd_waddr[gi*AW +: AW] == addr)
                                 & (addr != '0);
            end

            // Youngest matching producer wins; older ones are shadowed.
            always_comb begin
                win = '0;
                for (int i = 0; i < NFWD; i++) begin
                    if (match[i] && (win == '0)) begin
                        win[i] = 1'b1;
                    end
                end
            end

            always_comb begin
                win_pad           = '0;
                win_pad[NFWD-1:0] = win;
            end

            assign sel      = fwd_sel(win_pad);
            assign any_fwd  = |match;
            assign wb_match = wb_we & (wb_waddr == addr) & (addr != '0);

            assign val   = any_fwd  ? fwd_data[sel] :
                           wb_match ? wb_wdata      : rf_val;
            // Only the winner's readiness matters.
            assign stall = need & any_fwd & ~rdy_pad[sel];
        end
    endgenerate

    assign ready_go    = ~(g_src[0].stall | g_src[1].stall);
    assign ds_allowin  = ~ds_valid_q | (ready_go & es_allowin);
    assign ds2es_valid = ds_valid_q & ready_go & ~flush;
    assign ds_fire     = ds2es_valid & es_allowin;
    // A taken branch leaving ID means whatever IF offers this cycle is wrong-path.
    assign br_kill     = ds_fire & br_taken;

    always_comb begin
        ds_valid_d  = ds_valid_q;
        ds_inst_d   = ds_inst_q;
        ds_pc_d     = ds_pc_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            ds_valid_d = 1'b0;
        end else if (br_kill) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs2ds_valid;
        end

        if (fs2ds_valid && ds_allowin && !flush && !br_kill) begin
            ds_inst_d = fs2ds_bus[2*XLEN-1:XLEN];
            ds_pc_d   = fs2ds_bus[XLEN-1:0];
        end

        if (ds_valid_q && !ready_go && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_valid_q  <= 1'b0;
            ds_inst_q   <= '0;
            ds_pc_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            ds_inst_q   <= ds_inst_d;
            ds_pc_q     <= ds_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ds_inst   = ds_inst_q;
    assign ds_pc     = ds_pc_q;
    assign stall_cnt = stall_cnt_q;
    assign rj_value  = g_src[0].val;
    assign rkd_value = g_src[1].val;

endmodule

// File: tb/tb_id_fwd_stage.sv
// ----------------------------------------------------------------------------
// tb_id_fwd_stage
//   Drives id_fwd_stage with directed scenarios and randomized traffic and
//   compares every output each cycle against a behavioural model: a register
//   array plus a youngest-first scan of the producer list.
// ----------------------------------------------------------------------------
module tb_id_fwd_stage;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NFWD  = 3;
    localparam int CNT_W = 32;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 fs2ds_valid;
    logic                 ds_allowin;
    logic [2*XLEN-1:0]    fs2ds_bus;
    logic                 es_allowin;
    logic                 ds2es_valid;
    logic [XLEN-1:0]      ds_inst;
    logic [XLEN-1:0]      ds_pc;
    logic [AW-1:0]        dec_raddr1;
    logic [AW-1:0]        dec_raddr2;
    logic                 dec_need1;
    logic                 dec_need2;
    logic                 br_taken;
    logic                 flush;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_waddr;
    logic [NFWD*XLEN-1:0] fwd_wdata;
    logic [NFWD-1:0]      fwd_rdy;
    logic                 wb_we;
    logic [AW-1:0]        wb_waddr;
    logic [XLEN-1:0]      wb_wdata;
    logic [XLEN-1:0]      rj_value;
    logic [XLEN-1:0]      rkd_value;
    logic [CNT_W-1:0]     stall_cnt;

    always #5 clk = ~clk;

    id_fwd_stage #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .NFWD  (NFWD),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .fs2ds_valid (fs2ds_valid),
        .ds_allowin  (ds_allowin),
        .fs2ds_bus   (fs2ds_bus),
        .es_allowin  (es_allowin),
        .ds2es_valid (ds2es_valid),
        .ds_inst     (ds_inst),
        .ds_pc       (ds_pc),
        .dec_raddr1  (dec_raddr1),
        .dec_raddr2  (dec_raddr2),
        .dec_need1   (dec_need1),
        .dec_need2   (dec_need2),
        .br_taken    (br_taken),
        .flush       (flush),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_rdy     (fwd_rdy),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .rj_value    (rj_value),
        .rkd_value   (rkd_value),
        .stall_cnt   (stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic             m_valid;
    logic [XLEN-1:0]  m_inst, m_pc;
    logic [CNT_W-1:0] m_cnt;
    logic [XLEN-1:0]  m_rf [NREG];
    bit               m_known [NREG];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Operand lookup: youngest producer naming the register, then WB, then the array.
    function automatic void resolve(input logic [AW-1:0] a, input logic need,
                                    output logic [XLEN-1:0] v, output bit known,
                                    output bit stl);
        v = '0; known = 1'b1; stl = 1'b0;
        if (a == '0) return;
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == a)) begin
                v   = fwd_wdata[i*XLEN +: XLEN];
                stl = need && !fwd_rdy[i];
                return;
            end
        end
        if (wb_we && (wb_waddr == a)) begin
            v = wb_wdata;
            return;
        end
        v     = m_rf[a];
        known = m_known[a];
    endfunction

    task automatic idle();
        resetn      = 1'b1;
        fs2ds_valid = 1'b0;
        fs2ds_bus   = '0;
        es_allowin  = 1'b1;
        dec_raddr1  = '0;
        dec_raddr2  = '0;
        dec_need1   = 1'b0;
        dec_need2   = 1'b0;
        br_taken    = 1'b0;
        flush       = 1'b0;
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        fwd_rdy     = '0;
        wb_we       = 1'b0;
        wb_waddr    = '0;
        wb_wdata    = '0;
    endtask

    task automatic rand_inputs();
        fs2ds_valid = ($urandom_range(0, 9) < 7);
        fs2ds_bus   = {$urandom, $urandom};
        es_allowin  = ($urandom_range(0, 9) < 7);
        dec_raddr1  = AW'($urandom_range(0, 7));
        dec_raddr2  = AW'($urandom_range(0, 7));
        dec_need1   = $urandom_range(0, 1) == 1;
        dec_need2   = $urandom_range(0, 1) == 1;
        br_taken    = ($urandom_range(0, 9) == 0);
        flush       = ($urandom_range(0, 19) == 0);
        fwd_we      = NFWD'($urandom);
        for (int i = 0; i < NFWD; i++) begin
            fwd_waddr[i*AW +: AW]     = AW'($urandom_range(0, 7));
            fwd_wdata[i*XLEN +: XLEN] = $urandom;
            fwd_rdy[i]                = ($urandom_range(0, 3) != 0);
        end
        wb_we    = $urandom_range(0, 1) == 1;
        wb_waddr = AW'($urandom_range(0, 7));
        wb_wdata = $urandom;
    endtask

    // Called just after a falling edge with inputs already applied: checks
    // outputs against the model, advances the model, moves to the next cycle.
    task automatic step();
        logic [XLEN-1:0] v1, v2;
        bit k1, k2, s1, s2, rg, alw, ov, fire;
        #1;
        resolve(dec_raddr1, dec_need1, v1, k1, s1);
        resolve(dec_raddr2, dec_need2, v2, k2, s2);
        rg   = !(s1 || s2);
        alw  = !m_valid || (rg && es_allowin);
        ov   = m_valid && rg && !flush;
        fire = ov && es_allowin;
        chk("ds2es_valid", ds2es_valid, ov);
        chk("ds_allowin",  ds_allowin,  alw);
        chk("ds_inst",     ds_inst,     m_inst);
        chk("ds_pc",       ds_pc,       m_pc);
        chk("stall_cnt",   stall_cnt,   m_cnt);
        if (k1) chk("rj_value",  rj_value,  v1);
        if (k2) chk("rkd_value", rkd_value, v2);
        if (fire)
            $display("xfer pc=%08h inst=%08h rj=%08h rkd=%08h br=%0b",
                     m_pc, m_inst, v1, v2, br_taken);

        if (wb_we && (wb_waddr != '0)) begin
            m_rf[wb_waddr]    = wb_wdata;
            m_known[wb_waddr] = 1'b1;
        end
        if (!resetn) begin
            m_valid = 1'b0; m_inst = '0; m_pc = '0; m_cnt = '0;
        end else begin
            if (m_valid && !rg && !flush && (m_cnt != '1)) m_cnt = m_cnt + 1;
            if (fs2ds_valid && alw && !flush && !(fire && br_taken)) begin
                m_inst = fs2ds_bus[2*XLEN-1:XLEN];
                m_pc   = fs2ds_bus[XLEN-1:0];
            end
            if (flush)                 m_valid = 1'b0;
            else if (fire && br_taken) m_valid = 1'b0;
            else if (alw)              m_valid = fs2ds_valid;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [XLEN-1:0] inst, input logic [XLEN-1:0] pc);
        idle();
        fs2ds_valid = 1'b1;
        fs2ds_bus   = {inst, pc};
        es_allowin  = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_rf[r] = '0; m_known[r] = (r == 0);
        end
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0; m_inst = '0; m_pc = '0; m_cnt = '0;
        #1;
        chk("rst_ds2es_valid", ds2es_valid, 1'b0);
        chk("rst_ds_allowin",  ds_allowin,  1'b1);
        chk("rst_ds_inst",     ds_inst,     '0);
        chk("rst_ds_pc",       ds_pc,       '0);
        chk("rst_stall_cnt",   stall_cnt,   '0);
        @(negedge clk);

        // Fill the register file; each write is also read through the WB bypass.
        for (int r = 1; r < NREG; r++) begin
            idle();
            wb_we = 1'b1; wb_waddr = AW'(r); wb_wdata = $urandom; dec_raddr1 = AW'(r);
            step();
        end

        // 1: EX forward, ready
        load(32'h1111_0001, 32'h0000_1000);
        idle();
        es_allowin = 1'b0;
        fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd5; fwd_wdata[0 +: XLEN] = 32'h11; fwd_rdy = 3'b111;
        dec_raddr1 = 5'd5; dec_need1 = 1'b1;
        #1;
        chk("t1_rj", rj_value, 32'h11);
        chk("t1_valid", ds2es_valid, 1'b1);
        step();

        // 2: pending load in EX stalls one cycle, then forwards from slot 1
        idle();
        fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd6; fwd_rdy = 3'b000;
        dec_raddr1 = 5'd6; dec_need1 = 1'b1;
        #1;
        chk("t2_stall_valid", ds2es_valid, 1'b0);
        step();
        chk("t2_cnt", stall_cnt, 32'd1);
        idle();
        fwd_we = 3'b010; fwd_waddr[AW +: AW] = 5'd6; fwd_wdata[XLEN +: XLEN] = 32'h22; fwd_rdy = 3'b010;
        dec_raddr1 = 5'd6; dec_need1 = 1'b1;
        #1;
        chk("t2_rj", rj_value, 32'h22);
        chk("t2_fire", ds2es_valid, 1'b1);
        step();

        // 3: younger ready match hides older not-ready match
        load(32'h3333_0003, 32'h0000_3000);
        idle();
        es_allowin = 1'b0;
        fwd_we = 3'b101;
        fwd_waddr[0 +: AW] = 5'd7; fwd_wdata[0 +: XLEN] = 32'hA;
        fwd_waddr[2*AW +: AW] = 5'd7; fwd_wdata[2*XLEN +: XLEN] = 32'hB;
        fwd_rdy = 3'b001;
        dec_raddr1 = 5'd7; dec_need1 = 1'b1;
        #1;
        chk("t3_rj", rj_value, 32'hA);
        chk("t3_valid", ds2es_valid, 1'b1);
        step();

        // 4: r0 never forwards
        idle();
        es_allowin = 1'b0;
        fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd0; fwd_wdata[0 +: XLEN] = 32'hFF; fwd_rdy = 3'b000;
        dec_raddr1 = 5'd0; dec_need1 = 1'b1;
        #1;
        chk("t4_rj", rj_value, 32'h0);
        chk("t4_valid", ds2es_valid, 1'b1);
        step();

        // 5: flush during a stall drops the instruction and the offered payload
        idle();
        es_allowin = 1'b0;
        fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd6; fwd_rdy = 3'b000;
        dec_raddr1 = 5'd6; dec_need1 = 1'b1;
        step();
        flush = 1'b1; fs2ds_valid = 1'b1; fs2ds_bus = {32'h5555_0005, 32'h0000_5000};
        step();
        chk("t5_valid", ds2es_valid, 1'b0);
        chk("t5_allowin", ds_allowin, 1'b1);
        chk("t5_pc_kept", ds_pc, 32'h0000_3000);
        chk("t5_cnt", stall_cnt, 32'd2);
        idle();
        fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd6; fwd_rdy = 3'b000;
        dec_raddr1 = 5'd6; dec_need1 = 1'b1;
        step();
        chk("t5_cnt_stop", stall_cnt, 32'd2);

        // 6: taken branch kills wrong-path fetch; backpressure holds payload
        load(32'h6666_0006, 32'h0000_6000);
        idle();
        br_taken = 1'b1; fs2ds_valid = 1'b1; fs2ds_bus = {32'h7777_0007, 32'h0000_7000};
        step();
        chk("t6_valid", ds2es_valid, 1'b0);
        chk("t6_allowin", ds_allowin, 1'b1);
        chk("t6_pc_kept", ds_pc, 32'h0000_6000);
        load(32'h8888_0008, 32'h0000_8000);
        for (int c = 0; c < 3; c++) begin
            idle();
            es_allowin = 1'b0; fs2ds_valid = 1'b1; fs2ds_bus = {$urandom, $urandom};
            step();
            chk("t6_inst_hold", ds_inst, 32'h8888_0008);
            chk("t6_pc_hold", ds_pc, 32'h0000_8000);
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            rand_inputs();
            resetn = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
